hicore_rob_ctrl: RTL

Reorder-buffer controller that sits between dispatch/execute and the commit stage. It allocates in-order entries at dispatch and marks entries done from two writeback ports. It presents the oldest completed entry to commit through a valid/ready retire handshake. A commit-generated flush empties it.

---
 rtl/hicore_rob_pkg.sv | 33 +++
 rtl/hicore_rob_ctrl_if.sv | 73 +++++++
 rtl/hicore_rob_entry_ram.sv | 76 +++++++
 rtl/hicore_rob_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/hicore_rob_pkg.sv
// rtl/hicore_rob_pkg.sv - shared widths, entry record and helpers for the reorder buffer
package hicore_rob_pkg;

  localparam int RFIDX_W  = 5;
  localparam int CSRIDX_W = 12;
  localparam int REG_W    = 32;
  localparam int PC_W     = 32;
  localparam int EXCP_W   = 4;
  localparam int IRQ_W    = 3;
  localparam int WB_W     = PC_W + IRQ_W + EXCP_W;

  // One reorder-buffer slot; info is packed {pc, irq, excp}
  typedef struct packed {
    logic                valid;
    logic                done;
    logic                rd_need;
    logic [RFIDX_W-1:0]  rd_idx;
    logic [REG_W-1:0]    rd_data;
    logic                csr_need;
    logic [CSRIDX_W-1:0] csr_idx;
    logic [REG_W-1:0]    csr_data;
    logic                fence_i;
    logic                mret;
    logic [PC_W-1:0]     next_pc;
    logic [WB_W-1:0]     info;
  } rob_entry_t;

  // Exception bits sit in the least significant end of the info word
  function automatic logic [EXCP_W-1:0] info_excp(input logic [WB_W-1:0] info);
    return info[EXCP_W-1:0];
  endfunction

endpackage

// File: rtl/hicore_rob_ctrl_if.sv
// rtl/hicore_rob_ctrl_if.sv - dispatch, writeback and retire signal bundle of the reorder buffer
interface hicore_rob_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
);
  import hicore_rob_pkg::*;

  logic                disp_valid;
  logic                disp_ready;
  logic [TAG_W-1:0]    disp_tag;
  logic                disp_rd_need;
  logic [RFIDX_W-1:0]  disp_rd_idx;
  logic                disp_csr_need;
  logic [CSRIDX_W-1:0] disp_csr_idx;
  logic                disp_fence_i_op;
  logic                disp_mret_op;
  logic [WB_W-1:0]     disp_info;

  logic                wb0_valid;
  logic [TAG_W-1:0]    wb0_tag;
  logic [REG_W-1:0]    wb0_rd_data;
  logic [REG_W-1:0]    wb0_csr_data;
  logic [PC_W-1:0]     wb0_next_pc;
  logic [EXCP_W-1:0]   wb0_excp;

  logic                wb1_valid;
  logic [TAG_W-1:0]    wb1_tag;
  logic [REG_W-1:0]    wb1_rd_data;
  logic [REG_W-1:0]    wb1_csr_data;
  logic [PC_W-1:0]     wb1_next_pc;
  logic [EXCP_W-1:0]   wb1_excp;

  logic                rob_valid;
  logic                rob_ready;
  logic                rob_rd_need;
  logic [RFIDX_W-1:0]  rob_rd_idx;
  logic [REG_W-1:0]    rob_rd_data;
  logic                rob_csr_need;
  logic [CSRIDX_W-1:0] rob_csr_idx;
  logic [REG_W-1:0]    rob_csr_data;
  logic                rob_fence_i_op;
  logic                rob_mret_op;
  logic [PC_W-1:0]     rob_next_pc;
  logic [WB_W-1:0]     rob_info;

  logic                flush;
  logic                rob_empty;
  logic                rob_full;
  logic [TAG_W:0]      rob_count;

  modport master (
    output disp_valid, disp_rd_need, disp_rd_idx, disp_csr_need, disp_csr_idx,
           disp_fence_i_op, disp_mret_op, disp_info,
           wb0_valid, wb0_tag, wb0_rd_data, wb0_csr_data, wb0_next_pc, wb0_excp,
           wb1_valid, wb1_tag, wb1_rd_data, wb1_csr_data, wb1_next_pc, wb1_excp,
           rob_valid, flush,
    input  disp_ready, disp_tag, rob_ready, rob_rd_need, rob_rd_idx, rob_rd_data,
           rob_csr_need, rob_csr_idx, rob_csr_data, rob_fence_i_op, rob_mret_op,
           rob_next_pc, rob_info, rob_empty, rob_full, rob_count
  );

  modport slave (
    input  disp_valid, disp_rd_need, disp_rd_idx, disp_csr_need, disp_csr_idx,
           disp_fence_i_op, disp_mret_op, disp_info,
           wb0_valid, wb0_tag, wb0_rd_data, wb0_csr_data, wb0_next_pc, wb0_excp,
           wb1_valid, wb1_tag, wb1_rd_data, wb1_csr_data, wb1_next_pc, wb1_excp,
           rob_valid, flush,
    output disp_ready, disp_tag, rob_ready, rob_rd_need, rob_rd_idx, rob_rd_data,
           rob_csr_need, rob_csr_idx, rob_csr_data, rob_fence_i_op, rob_mret_op,
           rob_next_pc, rob_info, rob_empty, rob_full, rob_count
  );

endinterface

// File: rtl/hicore_rob_entry_ram.sv
// rtl/hicore_rob_entry_ram.sv - reorder-buffer slot array with dispatch write, two writeback merges and head read
module hicore_rob_entry_ram
  import hicore_rob_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  rob_entry_t        wr_entry,
  input  logic              wb0_en,
  input  logic [TAG_W-1:0]  wb0_tag,
  input  logic [REG_W-1:0]  wb0_rd_data,
  input  logic [REG_W-1:0]  wb0_csr_data,
  input  logic [PC_W-1:0]   wb0_next_pc,
  input  logic [EXCP_W-1:0] wb0_excp,
  input  logic              wb1_en,
  input  logic [TAG_W-1:0]  wb1_tag,
  input  logic [REG_W-1:0]  wb1_rd_data,
  input  logic [REG_W-1:0]  wb1_csr_data,
  input  logic [PC_W-1:0]   wb1_next_pc,
  input  logic [EXCP_W-1:0] wb1_excp,
  input  logic              rd_clr_en,
  input  logic [TAG_W-1:0]  rd_tag,
  output rob_entry_t        rd_entry
);

  rob_entry_t mem [DEPTH];
  logic       wb0_hit;
  logic       wb1_hit;

  // Writebacks only land on live slots; port 1 yields to port 0 on a shared tag
  always_comb begin
    wb0_hit = wb0_en & mem[wb0_tag].valid;
    wb1_hit = wb1_en & mem[wb1_tag].valid & ~(wb0_en & (wb0_tag == wb1_tag));
  end

  assign rd_entry = mem[rd_tag];

  // Slot update: bulk clear dominates, otherwise dispatch fill, writeback merge and retire release
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].done  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_tag == TAG_W'(i))) begin
          mem[i] <= wr_entry;
        end
        if (wb1_hit && (wb1_tag == TAG_W'(i))) begin
          mem[i].done               <= 1'b1;
          mem[i].rd_data            <= wb1_rd_data;
          mem[i].csr_data           <= wb1_csr_data;
          mem[i].next_pc            <= wb1_next_pc;
          mem[i].info[EXCP_W-1:0]   <= info_excp(mem[i].info) | wb1_excp;
        end
        if (wb0_hit && (wb0_tag == TAG_W'(i))) begin
          mem[i].done               <= 1'b1;
          mem[i].rd_data            <= wb0_rd_data;
          mem[i].csr_data           <= wb0_csr_data;
          mem[i].next_pc            <= wb0_next_pc;
          mem[i].info[EXCP_W-1:0]   <= info_excp(mem[i].info) | wb0_excp;
        end
        if (rd_clr_en && (rd_tag == TAG_W'(i))) begin
          mem[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hicore_rob_ctrl.sv
// rtl/hicore_rob_ctrl.sv - reorder-buffer controller: in-order allocate, out-of-order complete, in-order retire
module hicore_rob_ctrl
  import hicore_rob_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  hicore_rob_ctrl_if.slave       bus
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  logic             disp_ready_w;
  logic             rob_ready_w;
  logic             disp_fire;
  logic             retire_fire;
  rob_entry_t       head_entry;
  rob_entry_t       disp_entry;

  // Handshake qualification; readiness comes from registered state only
  always_comb begin
    disp_ready_w = (count != FULL_CNT);
    rob_ready_w  = head_entry.valid & head_entry.done;
    disp_fire    = bus.disp_valid & disp_ready_w;
    retire_fire  = bus.rob_valid & rob_ready_w;
  end

  // Fresh slot image from the dispatch fields; results arrive later by writeback
  always_comb begin
    disp_entry          = '0;
    disp_entry.valid    = 1'b1;
    disp_entry.done     = 1'b0;
    disp_entry.rd_need  = bus.disp_rd_need;
    disp_entry.rd_idx   = bus.disp_rd_idx;
    disp_entry.csr_need = bus.disp_csr_need;
    disp_entry.csr_idx  = bus.disp_csr_idx;
    disp_entry.fence_i  = bus.disp_fence_i_op;
    disp_entry.mret     = bus.disp_mret_op;
    disp_entry.info     = bus.disp_info;
  end

  // Pointer and occupancy tracking; flush rewinds everything to slot 0
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (disp_fire) begin
        tail <= tail + TAG_W'(1);
      end
      if (retire_fire) begin
        head <= head + TAG_W'(1);
      end
      case ({disp_fire, retire_fire})
        2'b10:   count <= count + (TAG_W + 1)'(1);
        2'b01:   count <= count - (TAG_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  hicore_rob_entry_ram #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_ram (
    .clk          (clk),
    .rst          (rst),
    .clear        (bus.flush),
    .wr_en        (disp_fire),
    .wr_tag       (tail),
    .wr_entry     (disp_entry),
    .wb0_en       (bus.wb0_valid),
    .wb0_tag      (bus.wb0_tag),
    .wb0_rd_data  (bus.wb0_rd_data),
    .wb0_csr_data (bus.wb0_csr_data),
    .wb0_next_pc  (bus.wb0_next_pc),
    .wb0_excp     (bus.wb0_excp),
    .wb1_en       (bus.wb1_valid),
    .wb1_tag      (bus.wb1_tag),
    .wb1_rd_data  (bus.wb1_rd_data),
    .wb1_csr_data (bus.wb1_csr_data),
    .wb1_next_pc  (bus.wb1_next_pc),
    .wb1_excp     (bus.wb1_excp),
    .rd_clr_en    (retire_fire),
    .rd_tag       (head),
    .rd_entry     (head_entry)
  );

  assign bus.disp_ready     = disp_ready_w;
  assign bus.disp_tag       = tail;
  assign bus.rob_ready      = rob_ready_w;
  assign bus.rob_rd_need    = head_entry.rd_need;
  assign bus.rob_rd_idx     = head_entry.rd_idx;
  assign bus.rob_rd_data    = head_entry.rd_data;
  assign bus.rob_csr_need   = head_entry.csr_need;
  assign bus.rob_csr_idx    = head_entry.csr_idx;
  assign bus.rob_csr_data   = head_entry.csr_data;
  assign bus.rob_fence_i_op = head_entry.fence_i;
  assign bus.rob_mret_op    = head_entry.mret;
  assign bus.rob_next_pc    = head_entry.next_pc;
  assign bus.rob_info       = head_entry.info;
  assign bus.rob_empty      = (count == '0);
  assign bus.rob_full       = (count == FULL_CNT);
  assign bus.rob_count      = count;

endmodule
